decode_stage_pipe: RTL and testbench
====================================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: register and data width.
REQ-002 SHALL have parameter NB_PC, default 32: PC width; the jump address form requires 32.
REQ-003 SHALL have parameter N_REGS, default 32: register count, a power of two; NB_REG = clog2(N_REGS).
REQ-004 i_clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_enable  in  1  stage advance (debug step); low freezes all state, including register-file writes.
REQ-007 i_flush  in  1  discards the instruction in ID (branch taken later in the pipe).
REQ-008 i_valid / i_inst / i_pc  in  1/32/NB_PC  IF/ID contents.
REQ-009 i_wb_reg_write / i_wb_write_reg / i_wb_write_data  in  1/NB_REG/NB_DATA  WB write port.
REQ-010 i_dbg_addr  in  NB_REG  debug read address; o_dbg_data  out  NB_DATA  combinational register read.
REQ-011 o_stall  out  1  combinational load-use stall; IF holds PC and IF/ID while high.
REQ-012 o_jump / o_jump_address  out  1/NB_PC  combinational J redirect.
REQ-013 o_valid  out  1  registered: the ID/EX slot holds a real instruction.
REQ-014 o_ctrl  out  8  registered {reg_dest, alu_src, mem_read, mem_write, branch, bne, reg_write, mem_to_reg}.
REQ-015 o_alu_op  out  6  registered opcode (funct for R-type is taken by EX from o_immediate[5:0]).
REQ-016 o_data_a / o_data_b / o_immediate  out  NB_DATA  registered rs value, rt value, sign-extended imm[15:0].
REQ-017 o_rs / o_rt / o_rd / o_pc  out  NB_REG/NB_REG/NB_REG/NB_PC  registered fields and PC.

Function
REQ-018 Latency SHALL be one cycle: the instruction in ID at edge N appears on the ID/EX outputs after edge N.
REQ-019 Decode SHALL support R-type(000000), LW(100011), SW(101011), BEQ(000100), BNE(000101), ADDI(001000) and J(000010); any other opcode yields all-zero o_ctrl.
REQ-020 Register 0 SHALL read 0; a write to register 0 SHALL be ignored.
REQ-021 Register-file write SHALL occur at the edge when i_enable & i_wb_reg_write are both high.
REQ-022 Source-use rule: rs is used by all opcodes except J; rt is used by R-type, SW, BEQ and BNE.
REQ-023 o_stall = i_valid & !i_flush & o_valid & ctrl.mem_read & o_rt!=0 & ((rs used & rs==o_rt) | (rt used & rt==o_rt)).
REQ-024 On a stall or flush, or when i_valid is low, the enabled edge SHALL load a bubble: o_valid=0 and o_ctrl=0; data fields are don't-care.
REQ-025 i_flush SHALL take priority over a stall: o_stall=0 and o_jump=0 whenever i_flush is high.
REQ-026 o_jump = i_valid & opcode J & !o_stall & !i_flush; o_jump_address = {i_pc[31:28], i_inst[25:0], 2'b00}.
REQ-027 J SHALL enter ID/EX as a valid instruction with o_ctrl=0.
REQ-028 When i_enable is low, all registered outputs SHALL hold and o_stall/o_jump SHALL still be evaluated.

Reset
REQ-029 On i_reset at an edge, all registers SHALL clear to 0, including o_valid, o_ctrl, all data and field outputs, and every register-file entry; reset overrides i_enable.
REQ-030 Reset mid-stall SHALL leave o_stall=0 on the next cycle, because o_valid is 0.

Configuration
REQ-031 With DECODE_STAGE_BYPASS_EN defined, a same-cycle WB write to a nonzero register SHALL be forwarded to the rs/rt/debug reads (write-first).
REQ-032 Without DECODE_STAGE_BYPASS_EN, reads SHALL return the pre-write value (read-first).

Structure
REQ-033 A shared package SHALL hold the opcode constants, the o_ctrl bit indices and the NB_REG derivation.
REQ-034 The register file SHALL be the sub-module decode_regfile, with 2 read ports, 1 debug read port, 1 write port and the bypass macro applied inside it.

Verification
REQ-035 Write r5=0x1234 in WB; next cycle decode ADD r3,r5,r0 -> o_data_a=0x1234, o_ctrl.reg_dest=1, o_valid=1 after one edge.
REQ-036 LW r2,0(r1), then ADD r4,r2,r2 -> o_stall=1 for one cycle, one bubble (o_valid=0), ADD issued the following cycle.
REQ-037 J 0x0000040 at pc=0x80000010 -> o_jump=1 with o_jump_address=0x80000100; with i_flush also high -> o_jump=0 and a bubble.
REQ-038 Same-cycle WB write r7=0xAA with a read of r7 -> reads 0xAA with DECODE_STAGE_BYPASS_EN, the old value without it; a write to r0 always reads back 0.
REQ-039 i_enable=0 for 3 cycles mid-stream -> outputs frozen and no register write; i_reset during a stall -> all outputs 0 and o_stall=0.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions: opcodes, o_ctrl bit positions, register-address width and control decode.
package decode_stage_pipe_pkg;

    localparam int NB_OPCODE = 6;
    localparam int NB_CTRL   = 8;

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'b000000;
    localparam logic [NB_OPCODE-1:0] OP_LW    = 6'b100011;
    localparam logic [NB_OPCODE-1:0] OP_SW    = 6'b101011;
    localparam logic [NB_OPCODE-1:0] OP_BEQ   = 6'b000100;
    localparam logic [NB_OPCODE-1:0] OP_BNE   = 6'b000101;
    localparam logic [NB_OPCODE-1:0] OP_ADDI  = 6'b001000;
    localparam logic [NB_OPCODE-1:0] OP_J     = 6'b000010;

    localparam int CTRL_REG_DEST   = 7;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_BNE        = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    function automatic int nb_reg(input int n_regs);
        return (n_regs > 1) ? $clog2(n_regs) : 1;
    endfunction

    // J and unknown opcodes decode to no control activity at all.
    function automatic logic [NB_CTRL-1:0] decode_ctrl(input logic [NB_OPCODE-1:0] op);
        logic [NB_CTRL-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin c[CTRL_REG_DEST] = 1'b1; c[CTRL_REG_WRITE] = 1'b1; end
            OP_LW:    begin
                c[CTRL_ALU_SRC] = 1'b1; c[CTRL_MEM_READ] = 1'b1;
                c[CTRL_REG_WRITE] = 1'b1; c[CTRL_MEM_TO_REG] = 1'b1;
            end
            OP_SW:    begin c[CTRL_ALU_SRC] = 1'b1; c[CTRL_MEM_WRITE] = 1'b1; end
            OP_BEQ:   c[CTRL_BRANCH] = 1'b1;
            OP_BNE:   begin c[CTRL_BRANCH] = 1'b1; c[CTRL_BNE] = 1'b1; end
            OP_ADDI:  begin c[CTRL_ALU_SRC] = 1'b1; c[CTRL_REG_WRITE] = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bundles the IF/ID inputs, WB write port, debug port and ID/EX outputs of the decode stage.
interface decode_stage_pipe_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int N_REGS  = 32
);
    import decode_stage_pipe_pkg::*;
    localparam int NB_REG = nb_reg(N_REGS);

    logic                i_enable;
    logic                i_flush;
    logic                i_valid;
    logic [31:0]         i_inst;
    logic [NB_PC-1:0]    i_pc;
    logic                i_wb_reg_write;
    logic [NB_REG-1:0]   i_wb_write_reg;
    logic [NB_DATA-1:0]  i_wb_write_data;
    logic [NB_REG-1:0]   i_dbg_addr;
    logic [NB_DATA-1:0]  o_dbg_data;
    logic                o_stall;
    logic                o_jump;
    logic [NB_PC-1:0]    o_jump_address;
    logic                o_valid;
    logic [NB_CTRL-1:0]  o_ctrl;
    logic [NB_OPCODE-1:0] o_alu_op;
    logic [NB_DATA-1:0]  o_data_a;
    logic [NB_DATA-1:0]  o_data_b;
    logic [NB_DATA-1:0]  o_immediate;
    logic [NB_REG-1:0]   o_rs;
    logic [NB_REG-1:0]   o_rt;
    logic [NB_REG-1:0]   o_rd;
    logic [NB_PC-1:0]    o_pc;

    modport master (
        output i_enable, i_flush, i_valid, i_inst, i_pc,
               i_wb_reg_write, i_wb_write_reg, i_wb_write_data, i_dbg_addr,
        input  o_dbg_data, o_stall, o_jump, o_jump_address, o_valid, o_ctrl, o_alu_op,
               o_data_a, o_data_b, o_immediate, o_rs, o_rt, o_rd, o_pc
    );

    modport slave (
        input  i_enable, i_flush, i_valid, i_inst, i_pc,
               i_wb_reg_write, i_wb_write_reg, i_wb_write_data, i_dbg_addr,
        output o_dbg_data, o_stall, o_jump, o_jump_address, o_valid, o_ctrl, o_alu_op,
               o_data_a, o_data_b, o_immediate, o_rs, o_rt, o_rd, o_pc
    );
endinterface

// File: rtl/decode_regfile.sv
// Register file: two operand read ports, one debug read port, one write port; r0 is hardwired to zero.
// Define DECODE_STAGE_BYPASS_EN for write-first reads; otherwise reads are read-first.
module decode_regfile
    import decode_stage_pipe_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32
)(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_wr_en,
    input  logic [nb_reg(N_REGS)-1:0]   i_wr_addr,
    input  logic [NB_DATA-1:0]          i_wr_data,
    input  logic [nb_reg(N_REGS)-1:0]   i_rd_addr_a,
    input  logic [nb_reg(N_REGS)-1:0]   i_rd_addr_b,
    input  logic [nb_reg(N_REGS)-1:0]   i_rd_addr_dbg,
    output logic [NB_DATA-1:0]          o_rd_data_a,
    output logic [NB_DATA-1:0]          o_rd_data_b,
    output logic [NB_DATA-1:0]          o_rd_data_dbg
);
    logic [NB_DATA-1:0] r_regs [N_REGS];
    logic               w_we;

    assign w_we = i_enable && i_wr_en && (i_wr_addr != '0);

`ifdef DECODE_STAGE_BYPASS_EN
    assign o_rd_data_a   = (i_rd_addr_a == '0) ? '0 :
                           (w_we && i_rd_addr_a == i_wr_addr) ? i_wr_data : r_regs[i_rd_addr_a];
    assign o_rd_data_b   = (i_rd_addr_b == '0) ? '0 :
                           (w_we && i_rd_addr_b == i_wr_addr) ? i_wr_data : r_regs[i_rd_addr_b];
    assign o_rd_data_dbg = (i_rd_addr_dbg == '0) ? '0 :
                           (w_we && i_rd_addr_dbg == i_wr_addr) ? i_wr_data : r_regs[i_rd_addr_dbg];
`else
    assign o_rd_data_a   = (i_rd_addr_a == '0)   ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b   = (i_rd_addr_b == '0)   ? '0 : r_regs[i_rd_addr_b];
    assign o_rd_data_dbg = (i_rd_addr_dbg == '0) ? '0 : r_regs[i_rd_addr_dbg];
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end
endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: decode, register read, load-use stall, J redirect and the ID/EX pipeline register.
// Optional DECODE_STAGE_BYPASS_EN selects write-first register reads inside decode_regfile.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int N_REGS  = 32
)(
    input  logic               i_clock,
    input  logic               i_reset,
    decode_stage_pipe_if.slave io_dec
);
    localparam int NB_REG = nb_reg(N_REGS);

    logic [NB_OPCODE-1:0]      w_opcode;
    logic [NB_REG-1:0]         w_rs, w_rt, w_rd;
    logic [NB_CTRL-1:0]        w_ctrl;
    logic signed [NB_DATA-1:0] w_imm_ext;
    logic [NB_DATA-1:0]        w_rd_data_a, w_rd_data_b;
    logic                      w_rs_used, w_rt_used, w_hazard, w_stall, w_issue;

    logic                      r_valid_p1;
    logic [NB_CTRL-1:0]        r_ctrl_p1;
    logic [NB_OPCODE-1:0]      r_alu_op_p1;
    logic [NB_DATA-1:0]        r_data_a_p1, r_data_b_p1, r_imm_p1;
    logic [NB_REG-1:0]         r_rs_p1, r_rt_p1, r_rd_p1;
    logic [NB_PC-1:0]          r_pc_p1;

    function automatic logic signed [NB_DATA-1:0] sext16(input logic signed [15:0] imm);
        return NB_DATA'(imm);
    endfunction

    assign w_opcode  = io_dec.i_inst[31:26];
    assign w_rs      = io_dec.i_inst[21 +: NB_REG];
    assign w_rt      = io_dec.i_inst[16 +: NB_REG];
    assign w_rd      = io_dec.i_inst[11 +: NB_REG];
    assign w_ctrl    = decode_ctrl(w_opcode);
    assign w_imm_ext = sext16(io_dec.i_inst[15:0]);

    decode_regfile #(.NB_DATA(NB_DATA), .N_REGS(N_REGS)) u_regfile (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (io_dec.i_enable),
        .i_wr_en       (io_dec.i_wb_reg_write),
        .i_wr_addr     (io_dec.i_wb_write_reg),
        .i_wr_data     (io_dec.i_wb_write_data),
        .i_rd_addr_a   (w_rs),
        .i_rd_addr_b   (w_rt),
        .i_rd_addr_dbg (io_dec.i_dbg_addr),
        .o_rd_data_a   (w_rd_data_a),
        .o_rd_data_b   (w_rd_data_b),
        .o_rd_data_dbg (io_dec.o_dbg_data)
    );

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign w_rs_used = (w_opcode != OP_J);
    assign w_rt_used = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) ||
                       (w_opcode == OP_BEQ)   || (w_opcode == OP_BNE);
    assign w_hazard  = r_valid_p1 && r_ctrl_p1[CTRL_MEM_READ] && (r_rt_p1 != '0) &&
                       ((w_rs_used && w_rs == r_rt_p1) || (w_rt_used && w_rt == r_rt_p1));
    assign w_stall   = io_dec.i_valid && !io_dec.i_flush && w_hazard;
    assign w_issue   = io_dec.i_valid && !io_dec.i_flush && !w_stall;

    assign io_dec.o_stall        = w_stall;
    assign io_dec.o_jump         = w_issue && (w_opcode == OP_J);
    assign io_dec.o_jump_address = NB_PC'({io_dec.i_pc[NB_PC-1 -: 4], io_dec.i_inst[25:0], 2'b00});

    // ID -> EX boundary
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid_p1  <= 1'b0;
            r_ctrl_p1   <= '0;
            r_alu_op_p1 <= '0;
            r_data_a_p1 <= '0;
            r_data_b_p1 <= '0;
            r_imm_p1    <= '0;
            r_rs_p1     <= '0;
            r_rt_p1     <= '0;
            r_rd_p1     <= '0;
            r_pc_p1     <= '0;
        end else if (io_dec.i_enable) begin
            r_valid_p1  <= w_issue;
            r_ctrl_p1   <= w_issue ? w_ctrl : '0;
            r_alu_op_p1 <= w_opcode;
            r_data_a_p1 <= w_rd_data_a;
            r_data_b_p1 <= w_rd_data_b;
            r_imm_p1    <= w_imm_ext;
            r_rs_p1     <= w_rs;
            r_rt_p1     <= w_rt;
            r_rd_p1     <= w_rd;
            r_pc_p1     <= io_dec.i_pc;
        end
    end

    assign io_dec.o_valid     = r_valid_p1;
    assign io_dec.o_ctrl      = r_ctrl_p1;
    assign io_dec.o_alu_op    = r_alu_op_p1;
    assign io_dec.o_data_a    = r_data_a_p1;
    assign io_dec.o_data_b    = r_data_b_p1;
    assign io_dec.o_immediate = r_imm_p1;
    assign io_dec.o_rs        = r_rs_p1;
    assign io_dec.o_rt        = r_rt_p1;
    assign io_dec.o_rd        = r_rd_p1;
    assign io_dec.o_pc        = r_pc_p1;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe; expected ID/EX contents are queued as stimulus is driven.
module tb_decode_stage_pipe;
    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [5:0]  alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.NB_DATA(32), .NB_PC(32), .N_REGS(32)) bus ();

    decode_stage_pipe #(.NB_DATA(32), .NB_PC(32), .N_REGS(32)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_dec  (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] mrf [32];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [7:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 8'h82;
            6'h23:   return 8'h63;
            6'h2B:   return 8'h50;
            6'h04:   return 8'h08;
            6'h05:   return 8'h0C;
            6'h08:   return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.valid  = 1'b1;
        e.ctrl   = ref_ctrl(inst[31:26]);
        e.alu_op = inst[31:26];
        e.rs     = inst[25:21];
        e.rt     = inst[20:16];
        e.rd     = inst[15:11];
        e.a      = mrf[inst[25:21]];
        e.b      = mrf[inst[20:16]];
        e.imm    = {{16{inst[15]}}, inst[15:0]};
        e.pc     = pc;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.valid  = bus.o_valid;
        o.ctrl   = bus.o_ctrl;
        o.alu_op = bus.o_alu_op;
        o.a      = bus.o_data_a;
        o.b      = bus.o_data_b;
        o.imm    = bus.o_immediate;
        o.rs     = bus.o_rs;
        o.rt     = bus.o_rt;
        o.rd     = bus.o_rd;
        o.pc     = bus.o_pc;
        return o;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        bus.i_valid = v;
        bus.i_inst = inst;
        bus.i_pc = pc;
        bus.i_flush = fl;
        bus.i_wb_reg_write = we;
        bus.i_wb_write_reg = wr;
        bus.i_wb_write_data = wd;
        #1;
    endtask

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (mrf[i]) mrf[i] = '0;
        end else if (bus.i_enable && bus.i_wb_reg_write && bus.i_wb_write_reg != 5'd0) begin
            mrf[bus.i_wb_write_reg] = bus.i_wb_write_data;
        end
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_dbg_addr = 5'd3;
        drive(1'b1, enc_r(5'd5, 5'd5, 5'd3), 32'h40, 1'b0, 1'b1, 5'd3, 32'h5);
        for (int i = 0; i < 2; i++) begin
            step('0);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_outputs: got %h want %h", o, e); end
        end
        checks++;
        if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", bus.o_stall); end
        checks++;
        if (bus.o_dbg_data !== 32'h0) begin failures++; $display("FAIL reset_regfile: got %h want 0", bus.o_dbg_data); end
        rst = 1'b0;
        bus.i_enable = 1'b1;
    endtask

    task automatic test_wb_add();
        exp_t e, o;
        logic [31:0] insts [3];
        logic        vs [3];
        logic [4:0]  wrs [3];
        logic [31:0] wds [3];
        insts = '{32'h0, enc_r(5'd5, 5'd0, 5'd3), 32'h0};
        vs    = '{1'b0, 1'b1, 1'b0};
        wrs   = '{5'd5, 5'd1, 5'd2};
        wds   = '{32'h1234, 32'h100, 32'h22};
        bus.i_dbg_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            drive(vs[i], insts[i], 32'h100 + 32'(i * 4), 1'b0, 1'b1, wrs[i], wds[i]);
            if (i == 1) begin
                checks++;
                if (bus.o_dbg_data !== 32'h1234) begin failures++; $display("FAIL wb_dbg_read: got %h want 1234", bus.o_dbg_data); end
            end
            e = vs[i] ? model(insts[i], 32'h100 + 32'(i * 4)) : exp_t'('0);
            step(e);
            e = sb.pop_front(); o = observe(); checks++;
            if (e.valid ? (o !== e) : ({o.valid, o.ctrl} !== {e.valid, e.ctrl})) begin
                failures++; $display("FAIL wb_add_%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_decode();
        exp_t e, o;
        logic [31:0] insts [6];
        insts = '{enc_i(6'h2B, 5'd1, 5'd2, 16'h0008), enc_i(6'h04, 5'd1, 5'd5, 16'hFFFC),
                  enc_i(6'h05, 5'd2, 5'd5, 16'h0010), enc_i(6'h08, 5'd1, 5'd6, 16'h7FFF),
                  enc_i(6'h3F, 5'd1, 5'd2, 16'h8000), enc_r(5'd1, 5'd2, 5'd9)};
        for (int i = 0; i < 6; i++) begin
            drive((i != 5), insts[i], 32'h300 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'h0);
            e = (i != 5) ? model(insts[i], 32'h300 + 32'(i * 4)) : exp_t'('0);
            step(e);
            e = sb.pop_front(); o = observe(); checks++;
            if (e.valid ? (o !== e) : ({o.valid, o.ctrl} !== {e.valid, e.ctrl})) begin
                failures++; $display("FAIL decode_%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e, o;
        logic [31:0] insts [7];
        logic        stall_exp [7];
        insts = '{enc_i(6'h23, 5'd1, 5'd2, 16'h0), enc_r(5'd2, 5'd2, 5'd4), enc_r(5'd2, 5'd2, 5'd4),
                  enc_i(6'h23, 5'd1, 5'd2, 16'h0), enc_i(6'h08, 5'd1, 5'd2, 16'h1),
                  enc_i(6'h23, 5'd1, 5'd0, 16'h0), enc_r(5'd0, 5'd0, 5'd4)};
        stall_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, insts[i], 32'h400 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'h0);
            checks++;
            if (bus.o_stall !== stall_exp[i]) begin
                failures++; $display("FAIL load_use_stall_%0d: got %b want %b", i, bus.o_stall, stall_exp[i]);
            end
            e = stall_exp[i] ? exp_t'('0) : model(insts[i], 32'h400 + 32'(i * 4));
            step(e);
            e = sb.pop_front(); o = observe(); checks++;
            if (e.valid ? (o !== e) : ({o.valid, o.ctrl} !== {e.valid, e.ctrl})) begin
                failures++; $display("FAIL load_use_%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_jump();
        exp_t e, o;
        logic [31:0] j_inst;
        j_inst = {6'h02, 26'h0000040};
        drive(1'b1, j_inst, 32'h80000010, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_jump !== 1'b1) begin failures++; $display("FAIL jump_taken: got %b want 1", bus.o_jump); end
        checks++;
        if (bus.o_jump_address !== 32'h80000100) begin
            failures++; $display("FAIL jump_address: got %h want 80000100", bus.o_jump_address);
        end
        step(model(j_inst, 32'h80000010));
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL jump_issue: got %h want %h", o, e); end

        drive(1'b1, j_inst, 32'h80000010, 1'b1, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_jump !== 1'b0) begin failures++; $display("FAIL jump_flushed: got %b want 0", bus.o_jump); end
        step('0);
        e = sb.pop_front(); o = observe(); checks++;
        if ({o.valid, o.ctrl} !== {e.valid, e.ctrl}) begin failures++; $display("FAIL jump_flush_bubble: got %h want %h", o, e); end

        drive(1'b1, enc_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h600, 1'b0, 1'b0, 5'd0, 32'h0);
        step(model(enc_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h600));
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL flush_setup_lw: got %h want %h", o, e); end
        drive(1'b1, enc_r(5'd2, 5'd2, 5'd4), 32'h604, 1'b1, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL flush_over_stall: got %b want 0", bus.o_stall); end
        step('0);
        e = sb.pop_front(); o = observe(); checks++;
        if ({o.valid, o.ctrl} !== {e.valid, e.ctrl}) begin failures++; $display("FAIL flush_bubble: got %h want %h", o, e); end
    endtask

    task automatic test_bypass();
        exp_t e, o;
        logic [31:0] same_cycle;
`ifdef DECODE_STAGE_BYPASS_EN
        same_cycle = 32'hAA;
`else
        same_cycle = 32'h55;
`endif
        drive(1'b0, 32'h0, 32'h700, 1'b0, 1'b1, 5'd7, 32'h55);
        step('0);
        e = sb.pop_front(); o = observe(); checks++;
        if ({o.valid, o.ctrl} !== {e.valid, e.ctrl}) begin failures++; $display("FAIL bypass_setup: got %h want %h", o, e); end

        bus.i_dbg_addr = 5'd7;
        drive(1'b1, enc_r(5'd7, 5'd7, 5'd8), 32'h704, 1'b0, 1'b1, 5'd7, 32'hAA);
        checks++;
        if (bus.o_dbg_data !== same_cycle) begin
            failures++; $display("FAIL bypass_dbg: got %h want %h", bus.o_dbg_data, same_cycle);
        end
        e = model(enc_r(5'd7, 5'd7, 5'd8), 32'h704);
        e.a = same_cycle;
        e.b = same_cycle;
        step(e);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL bypass_operands: got %h want %h", o, e); end

        bus.i_dbg_addr = 5'd0;
        drive(1'b1, enc_r(5'd0, 5'd7, 5'd8), 32'h708, 1'b0, 1'b1, 5'd0, 32'hFF);
        checks++;
        if (bus.o_dbg_data !== 32'h0) begin failures++; $display("FAIL r0_write_dbg: got %h want 0", bus.o_dbg_data); end
        step(model(enc_r(5'd0, 5'd7, 5'd8), 32'h708));
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL r0_write_read: got %h want %h", o, e); end
        drive(1'b0, 32'h0, 32'h70C, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_dbg_data !== 32'h0) begin failures++; $display("FAIL r0_after_write: got %h want 0", bus.o_dbg_data); end
    endtask

    task automatic test_enable();
        exp_t e, o, last;
        last = model(enc_i(6'h08, 5'd1, 5'd9, 16'h5), 32'h500);
        drive(1'b1, enc_i(6'h08, 5'd1, 5'd9, 16'h5), 32'h500, 1'b0, 1'b0, 5'd0, 32'h0);
        step(last);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL enable_setup: got %h want %h", o, e); end

        bus.i_enable = 1'b0;
        drive(1'b1, enc_i(6'h2B, 5'd1, 5'd2, 16'h4), 32'h504, 1'b0, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step(last);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL enable_freeze_%0d: got %h want %h", i, o, e); end
        end
        bus.i_enable = 1'b1;
        bus.i_dbg_addr = 5'd9;
        drive(1'b0, 32'h0, 32'h508, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_dbg_data !== 32'h0) begin failures++; $display("FAIL enable_no_write: got %h want 0", bus.o_dbg_data); end

        last = model(enc_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h50C);
        drive(1'b1, enc_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h50C, 1'b0, 1'b0, 5'd0, 32'h0);
        step(last);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL stall_setup_lw: got %h want %h", o, e); end
        bus.i_enable = 1'b0;
        drive(1'b1, enc_r(5'd2, 5'd2, 5'd4), 32'h510, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL stall_while_frozen: got %b want 1", bus.o_stall); end
        step(last);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL frozen_hold: got %h want %h", o, e); end

        rst = 1'b1;
        step('0);
        rst = 1'b0;
        #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin failures++; $display("FAIL reset_in_stall: got %h want %h", o, e); end
        checks++;
        if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL stall_after_reset: got %b want 0", bus.o_stall); end
        bus.i_dbg_addr = 5'd1;
        #1;
        checks++;
        if (bus.o_dbg_data !== 32'h0) begin failures++; $display("FAIL regfile_after_reset: got %h want 0", bus.o_dbg_data); end
        bus.i_enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_dbg_addr = 5'd0;
        foreach (mrf[i]) mrf[i] = '0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_wb_add();
        test_decode();
        test_load_use();
        test_jump();
        test_bypass();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
